timer_sequencer: RTL

Run/pause/expire controller for a mm:ss countdown timer that sequences the two-rate tick divider. It programs the divider's rate select and phase-clear, consumes the selected one-cycle tick, and decrements a minutes:seconds count to 00:00. It raises a one-cycle `done` pulse and a held `alarm` on expiry. It sits between the debounced button logic and the display/alarm path.

---
 rtl/timer_sequencer_pkg.sv | 21 ++
 rtl/mmss_down_counter.sv | 52 +++++
 rtl/timer_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/timer_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the mm:ss countdown timer.
package timer_sequencer_pkg;

  localparam int MIN_W = 6;
  localparam int SEC_W = 6;

  localparam logic [MIN_W-1:0] DEF_MAX_MIN  = 6'd59;
  localparam logic [SEC_W-1:0] DEF_SEC_WRAP = 6'd59;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RUN     = 2'd1;
  localparam state_t ST_PAUSE   = 2'd2;
  localparam state_t ST_EXPIRED = 2'd3;

  function automatic logic [5:0] sat6(input logic [5:0] v, input logic [5:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/mmss_down_counter.sv
// Minutes:seconds down counter with parallel load and a look-ahead zero flag.
module mmss_down_counter
  import timer_sequencer_pkg::*;
#(
  parameter logic [SEC_W-1:0] SEC_WRAP = DEF_SEC_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MIN_W-1:0] load_min_i,
  input  logic [SEC_W-1:0] load_sec_i,
  input  logic             load_en_i,
  input  logic             dec_en_i,
  output logic [MIN_W-1:0] min_o,
  output logic [SEC_W-1:0] sec_o,
  output logic             zero_next_o
);

  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;

  always_comb begin
    min_d = min_q;
    sec_d = sec_q;
    if (load_en_i) begin
      min_d = load_min_i;
      sec_d = load_sec_i;
    end else if (dec_en_i) begin
      if (sec_q != '0) begin
        sec_d = sec_q - 1'b1;
      end else begin
        min_d = min_q - 1'b1;
        sec_d = SEC_WRAP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      sec_q <= '0;
    end else begin
      min_q <= min_d;
      sec_q <= sec_d;
    end
  end

  // Flag is valid whenever a decrement is requested this cycle.
  assign zero_next_o = (min_q == '0) && (sec_q == 6'd1);
  assign min_o       = min_q;
  assign sec_o       = sec_q;

endmodule

// File: rtl/timer_sequencer.sv
// Run/pause/expire sequencer: priority decode, FSM, divider control and alarm.
module timer_sequencer
  import timer_sequencer_pkg::*;
#(
  parameter logic [MIN_W-1:0] MAX_MIN  = DEF_MAX_MIN,
  parameter logic [SEC_W-1:0] SEC_WRAP = DEF_SEC_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             fast_i,
  input  logic [MIN_W-1:0] set_min_i,
  input  logic [SEC_W-1:0] set_sec_i,
  output logic             div_sel_o,
  output logic             div_clr_o,
  output logic [MIN_W-1:0] min_o,
  output logic [SEC_W-1:0] sec_o,
  output logic [1:0]       state_o,
  output logic             done_o,
  output logic             alarm_o
);

  state_t           state_q, state_d;
  logic [MIN_W-1:0] pre_min_q, pre_min_d;
  logic [SEC_W-1:0] pre_sec_q, pre_sec_d;
  logic             div_sel_q, div_sel_d;
  logic             div_clr_q, div_clr_d;
  logic             done_q, done_d;
  logic             alarm_q, alarm_d;

  logic [MIN_W-1:0] cnt_min;
  logic [SEC_W-1:0] cnt_sec;
  logic             zero_next;
  logic             cnt_load, cnt_dec;
  logic [MIN_W-1:0] ld_min;
  logic [SEC_W-1:0] ld_sec;
  logic             cnt_nonzero;

  assign cnt_nonzero = (cnt_min != '0) || (cnt_sec != '0);

  always_comb begin
    state_d   = state_q;
    pre_min_d = pre_min_q;
    pre_sec_d = pre_sec_q;
    div_sel_d = div_sel_q;
    div_clr_d = 1'b0;
    done_d    = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    ld_min    = pre_min_q;
    ld_sec    = pre_sec_q;

    if (clear_i) begin
      state_d  = ST_IDLE;
      cnt_load = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A start at 00:00 is not applicable, so a lower-priority load may act.
          if (start_i && cnt_nonzero) begin
            state_d   = ST_RUN;
            div_sel_d = fast_i;
            div_clr_d = 1'b1;
          end else if (load_i) begin
            pre_min_d = sat6(set_min_i, MAX_MIN);
            pre_sec_d = sat6(set_sec_i, SEC_WRAP);
            ld_min    = pre_min_d;
            ld_sec    = pre_sec_d;
            cnt_load  = 1'b1;
          end
        end
        ST_RUN: begin
          if (stop_i) begin
            state_d = ST_PAUSE;
          end else if (tick_i) begin
            cnt_dec = 1'b1;
            if (zero_next) begin
              state_d = ST_EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (start_i) state_d = ST_RUN;
        end
        default: ;
      endcase
    end

    alarm_d = (state_d == ST_EXPIRED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pre_min_q <= '0;
      pre_sec_q <= '0;
      div_sel_q <= 1'b0;
      div_clr_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_min_q <= pre_min_d;
      pre_sec_q <= pre_sec_d;
      div_sel_q <= div_sel_d;
      div_clr_q <= div_clr_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
    end
  end

  mmss_down_counter #(
    .SEC_WRAP(SEC_WRAP)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_min_i (ld_min),
    .load_sec_i (ld_sec),
    .load_en_i  (cnt_load),
    .dec_en_i   (cnt_dec),
    .min_o      (cnt_min),
    .sec_o      (cnt_sec),
    .zero_next_o(zero_next)
  );

  assign div_sel_o = div_sel_q;
  assign div_clr_o = div_clr_q;
  assign min_o     = cnt_min;
  assign sec_o     = cnt_sec;
  assign state_o   = state_q;
  assign done_o    = done_q;
  assign alarm_o   = alarm_q;

endmodule
